// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory.
// Data has priority, bounded by a starvation counter; stuck accesses are ended by a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              if_stall,
  output logic              d_stall,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [1:0]  STARVE_MAX = 2'd2;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  starve_cnt;
  logic [15:0] tmo_cnt;
  logic        cancel;
  logic        grant_i;
  logic        grant_d;
  logic        busy;
  logic        tmo_hit;
  logic        finish;

  function automatic logic [1:0] starve_inc(input logic [1:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + 2'd1;
  endfunction

  // Fetch wins only when data has been granted twice in a row over a waiting fetch.
  always_comb begin
    grant_i = if_req & ~if_flush & (~d_req | (starve_cnt == STARVE_MAX));
    grant_d = d_req & ~grant_i;
    busy    = (state == BUSY_I) | (state == BUSY_D);
    tmo_hit = busy & ~mem_ack & (tmo_cnt >= TMO_LAST);
    finish  = busy & (mem_ack | tmo_hit);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign mem_req  = busy;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      cancel     <= 1'b0;
      err        <= 1'b0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        cancel  <= 1'b0;
        if (grant_i) begin
          mem_addr   <= if_addr;
          mem_we     <= 1'b0;
          mem_wdata  <= '0;
          starve_cnt <= '0;
        end else if (grant_d) begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_wdata;
          if (if_req) starve_cnt <= starve_inc(starve_cnt);
        end
      end
      if (busy) begin
        if (!mem_ack) tmo_cnt <= tmo_cnt + 16'd1;
        if (state == BUSY_I) cancel <= cancel | if_flush;
        if (finish) begin
          mem_we <= 1'b0;
          if (tmo_hit) err <= 1'b1;
          // A flush arriving on the completing cycle still cancels the fetch.
          if (state == BUSY_I) begin
            if_rdata <= tmo_hit ? 32'h0 : mem_rdata;
            if_done  <= ~(cancel | if_flush);
          end else begin
            d_rdata <= tmo_hit ? 32'h0 : mem_rdata;
            d_done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expectations, a negedge
// monitor compares memory requests, done pulses and per-cycle probes.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              if_stall;
  logic              d_stall;
  logic              err;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .d_stall(d_stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  typedef struct packed {logic is_i; logic [31:0] data;} done_exp_t;
  typedef struct packed {logic [3:0] kind; logic [31:0] val;} probe_t;

  localparam logic [3:0] P_MEMREQ = 4'd0, P_MEMWE = 4'd1, P_IFDONE = 4'd2, P_DDONE = 4'd3,
                         P_IFSTALL = 4'd4, P_DSTALL = 4'd5, P_ERR = 4'd6, P_IFRDATA = 4'd7,
                         P_DRDATA = 4'd8, P_MEMADDR = 4'd9, P_MEMWDATA = 4'd10, P_BOUND = 4'd11;

  mem_exp_t    mem_q[$];
  done_exp_t   done_q[$];
  probe_t      probe_q[$];
  logic [31:0] ack_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_delay = 1;
  logic ack_en    = 1'b1;
  logic force_ack = 1'b0;
  logic finish_req = 1'b0;

  // Memory responder: acks on the ack_delay-th consecutive mem_req cycle.
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack   = force_ack;
      mem_rdata = force_ack ? 32'hFFFF_FFFF : 32'h0;
      if (mem_req === 1'b1 && reset === 1'b0) begin
        busy_cnt++;
        if (ack_en && !force_ack && busy_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = (ack_q.size() > 0) ? ack_q.pop_front() : 32'h0;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] probe_val(input logic [3:0] k);
    case (k)
      P_MEMREQ:   return 32'(mem_req);
      P_MEMWE:    return 32'(mem_we);
      P_IFDONE:   return 32'(if_done);
      P_DDONE:    return 32'(d_done);
      P_IFSTALL:  return 32'(if_stall);
      P_DSTALL:   return 32'(d_stall);
      P_ERR:      return 32'(err);
      P_IFRDATA:  return if_rdata;
      P_DRDATA:   return d_rdata;
      P_MEMADDR:  return mem_addr;
      P_MEMWDATA: return mem_wdata;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic string probe_name(input logic [3:0] k);
    case (k)
      P_MEMREQ:   return "mem_req";
      P_MEMWE:    return "mem_we";
      P_IFDONE:   return "if_done";
      P_DDONE:    return "d_done";
      P_IFSTALL:  return "if_stall";
      P_DSTALL:   return "d_stall";
      P_ERR:      return "err";
      P_IFRDATA:  return "if_rdata";
      P_DRDATA:   return "d_rdata";
      P_MEMADDR:  return "mem_addr";
      P_MEMWDATA: return "mem_wdata";
      default:    return "wait_bound";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sole owner of the counters.
  initial begin
    int       cycle;
    logic     prev_req;
    probe_t   p;
    mem_exp_t me;
    done_exp_t de;
    cycle    = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        chk(probe_name(p.kind), probe_val(p.kind), p.val);
      end
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        if (mem_q.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'h0);
        else begin
          me = mem_q.pop_front();
          chk("txn_mem_we", 32'(mem_we), 32'(me.we));
          chk("txn_mem_addr", mem_addr, me.addr);
          if (me.we) chk("txn_mem_wdata", mem_wdata, me.wdata);
        end
      end
      prev_req = mem_req;
      if (if_done === 1'b1 || d_done === 1'b1) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'(if_done | d_done), 32'h0);
        else begin
          de = done_q.pop_front();
          chk("done_kind_if", 32'(if_done), 32'(de.is_i));
          chk("done_kind_d", 32'(d_done), 32'(!de.is_i));
          chk("done_rdata", de.is_i ? if_rdata : d_rdata, de.data);
        end
      end
      if (finish_req || cycle > 3000) begin
        if (!finish_req) chk("global_cycle_budget", 32'(finish_req), 32'h1);
        chk("mem_q_left", 32'(mem_q.size()), 32'h0);
        chk("done_q_left", 32'(done_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [3:0] k, input logic [31:0] v);
    probe_t p;
    p.kind = k;
    p.val  = v;
    probe_q.push_back(p);
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  task automatic exp_done(input logic is_i, input logic [31:0] data);
    done_exp_t e;
    e.is_i = is_i; e.data = data;
    done_q.push_back(e);
  endtask

  // Returns with the clock positioned in the done cycle, or flags an expired bound.
  task automatic wait_done(input logic want_i, input logic any);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (any ? (if_done === 1'b1 || d_done === 1'b1)
              : (want_i ? if_done === 1'b1 : d_done === 1'b1)) hit = 1;
    end
    if (!hit) probe(P_BOUND, 32'h1);
  endtask

  initial begin
    int nd;
    int ni;
    bit hit;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    probe(P_MEMREQ, 0); probe(P_ERR, 0); probe(P_IFDONE, 0); probe(P_DDONE, 0);
    probe(P_MEMWE, 0); probe(P_IFRDATA, 0); probe(P_DRDATA, 0);
    probe(P_MEMADDR, 0); probe(P_MEMWDATA, 0);
    reset = 1'b0;
    tick();

    // Single fetch, ack on third mem_req cycle
    ack_delay = 3;
    ack_q.push_back(32'h00A0_0093);
    exp_mem(1'b0, 32'h40, 32'h0);
    exp_done(1'b1, 32'h00A0_0093);
    if_req = 1'b1; if_addr = 32'h40;
    tick(); probe(P_MEMREQ, 1); probe(P_IFSTALL, 1); probe(P_MEMWE, 0);
    tick(); probe(P_MEMREQ, 1);
    tick(); probe(P_MEMREQ, 1);
    tick(); probe(P_MEMREQ, 0); probe(P_IFDONE, 1); probe(P_IFSTALL, 0);
    probe(P_IFRDATA, 32'h00A0_0093);
    tick(); if_req = 1'b0; probe(P_IFDONE, 0);
    tick();

    // Simultaneous store and fetch: store first
    ack_delay = 1;
    ack_q.push_back(32'h0); ack_q.push_back(32'h1111_1111);
    exp_mem(1'b1, 32'h100, 32'h55); exp_mem(1'b0, 32'h80, 32'h0);
    exp_done(1'b0, 32'h0); exp_done(1'b1, 32'h1111_1111);
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55;
    tick(); probe(P_MEMWE, 1); probe(P_MEMADDR, 32'h100); probe(P_MEMWDATA, 32'h55);
    probe(P_IFSTALL, 1); probe(P_DSTALL, 1);
    wait_done(1'b0, 1'b0); probe(P_DSTALL, 0); probe(P_IFSTALL, 1);
    tick(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    wait_done(1'b1, 1'b0);
    tick(); if_req = 1'b0;
    tick();

    // Anti-starvation: grants D, D, I, D, D, I
    ack_q.push_back(32'hD0);  ack_q.push_back(32'hD1); ack_q.push_back(32'h1C0);
    ack_q.push_back(32'hD2);  ack_q.push_back(32'hD3); ack_q.push_back(32'h1C4);
    exp_mem(1'b0, 32'h200, 0); exp_mem(1'b0, 32'h204, 0); exp_mem(1'b0, 32'hC0, 0);
    exp_mem(1'b0, 32'h208, 0); exp_mem(1'b0, 32'h20C, 0); exp_mem(1'b0, 32'hC4, 0);
    exp_done(1'b0, 32'hD0);  exp_done(1'b0, 32'hD1); exp_done(1'b1, 32'h1C0);
    exp_done(1'b0, 32'hD2);  exp_done(1'b0, 32'hD3); exp_done(1'b1, 32'h1C4);
    if_req = 1'b1; if_addr = 32'hC0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    nd = 0; ni = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done(1'b0, 1'b1);
      if (d_done === 1'b1) begin
        nd++;
        if (nd == 4) d_req = 1'b0; else d_addr = d_addr + 32'd4;
      end
      if (if_done === 1'b1) begin
        ni++;
        if (ni == 2) if_req = 1'b0; else if_addr = 32'hC4;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Flush: suppressed grant in IDLE, then cancel during BUSY_I
    ack_delay = 3;
    if_req = 1'b1; if_addr = 32'h300; if_flush = 1'b1;
    tick(); probe(P_MEMREQ, 0); if_flush = 1'b0;
    exp_mem(1'b0, 32'h300, 0);
    ack_q.push_back(32'hDEAD_BEEF);
    tick(); probe(P_MEMREQ, 1); if_flush = 1'b1;
    tick(); if_flush = 1'b0; if_req = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (mem_req === 1'b0) hit = 1;
    end
    if (!hit) probe(P_BOUND, 1);
    probe(P_IFDONE, 0); probe(P_IFRDATA, 32'hDEAD_BEEF);
    tick(); probe(P_MEMREQ, 0); probe(P_IFDONE, 0);
    ack_delay = 2;
    ack_q.push_back(32'h1234_5678);
    exp_mem(1'b0, 32'h400, 0); exp_done(1'b0, 32'h1234_5678);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    tick(); probe(P_MEMREQ, 1);
    wait_done(1'b0, 1'b0);
    tick(); d_req = 1'b0;
    tick();

    // Timeout after TIMEOUT busy cycles without ack
    ack_en = 1'b0;
    exp_mem(1'b0, 32'h500, 0); exp_done(1'b0, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick(); probe(P_MEMREQ, 1); probe(P_ERR, 0);
    tick(); probe(P_MEMREQ, 1);
    tick(); probe(P_MEMREQ, 1);
    tick(); probe(P_MEMREQ, 1); probe(P_ERR, 0);
    tick(); probe(P_ERR, 1); probe(P_MEMREQ, 0); probe(P_DDONE, 1); probe(P_DRDATA, 0);
    tick(); d_req = 1'b0; probe(P_ERR, 1);
    tick(); probe(P_ERR, 1); probe(P_MEMREQ, 0);
    ack_en = 1'b1; ack_delay = 1;
    ack_q.push_back(32'hCAFE_0001);
    exp_mem(1'b0, 32'h600, 0); exp_done(1'b1, 32'hCAFE_0001);
    if_req = 1'b1; if_addr = 32'h600;
    wait_done(1'b1, 1'b0); probe(P_ERR, 1);
    tick(); if_req = 1'b0;
    tick();

    // Reset during BUSY_D, then a stray ack
    ack_en = 1'b0;
    exp_mem(1'b1, 32'h700, 32'hAA);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'hAA;
    tick(); probe(P_MEMREQ, 1); probe(P_MEMWE, 1);
    tick(); reset = 1'b1; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    tick(); probe(P_MEMREQ, 0); probe(P_DDONE, 0); probe(P_ERR, 0); probe(P_MEMWE, 0);
    probe(P_MEMADDR, 0); probe(P_MEMWDATA, 0); probe(P_IFRDATA, 0); probe(P_DRDATA, 0);
    reset = 1'b0; force_ack = 1'b1;
    tick(); force_ack = 1'b0; probe(P_MEMREQ, 0); probe(P_DDONE, 0); probe(P_DRDATA, 0);
    tick(); probe(P_MEMREQ, 0); probe(P_DDONE, 0); probe(P_IFDONE, 0);
    ack_en = 1'b1; ack_delay = 2;
    ack_q.push_back(32'h0BAD_F00D);
    exp_mem(1'b0, 32'h800, 0); exp_done(1'b1, 32'h0BAD_F00D);
    if_req = 1'b1; if_addr = 32'h800;
    wait_done(1'b1, 1'b0);
    tick(); if_req = 1'b0;
    tick(); tick();
    finish_req = 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack before flagging an error (1..65535).
REQ-003 SHALL have ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancel the outstanding fetch.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse: access complete, d_rdata valid for loads.
- d_rdata  out  32  load data.
- mem_req  out  1  request to the single-port memory.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read data.
- if_stall  out  1  if_req & ~if_done.
- d_stall  out  1  d_req & ~d_done.
- err  out  1  sticky timeout flag.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY_I, BUSY_D and DONE.
REQ-005 In IDLE, arbitration SHALL work as follows:
- d_req wins over if_req, unless starve_cnt == 2, in which case if_req wins.
- The winner's address, data and we are latched.
- The next state is BUSY_I or BUSY_D.
REQ-006 starve_cnt (2-bit) SHALL increment on each D grant while if_req=1, saturate at 2, and clear on any I grant.
REQ-007 In BUSY_x, mem_req SHALL be 1 with the latched mem_addr, mem_we and mem_wdata held stable. For BUSY_I, mem_we = 0.
REQ-008 When mem_ack=1 in BUSY_x:
- mem_rdata SHALL be registered into if_rdata or d_rdata.
- The state SHALL go to DONE.
REQ-009 In DONE, the matching if_done or d_done SHALL be 1 for exactly that cycle. Requests SHALL be ignored, and the next state SHALL be IDLE.
REQ-010 Latency: a request sampled in IDLE at cycle 0 gives mem_req=1 from cycle 1. An ack at cycle k gives done at cycle k+1 and IDLE at cycle k+2.
REQ-011 if_flush=1 SHALL be handled by state:
- In IDLE: it suppresses an I grant that cycle.
- In BUSY_I: it sets a cancel bit. The memory transaction still completes, DONE is entered, and if_done stays 0.
- Flush has no effect on D transactions.
REQ-012 The timeout counter SHALL behave as follows:
- It is 16-bit, cleared on entry to BUSY_x, and incremented each BUSY cycle without mem_ack.
- When it reaches TIMEOUT, err is set, the state goes to DONE, and done is pulsed with rdata = 0.
REQ-013 err SHALL remain 1 until reset.
REQ-014 mem_ack outside BUSY_x SHALL be ignored.
REQ-015 Only one memory transaction SHALL be outstanding at any time.
REQ-016 if_stall and d_stall SHALL be combinational; all other outputs SHALL be registered or decoded from state.

Reset
REQ-017 reset=1 on a clock edge SHALL set:
- state = IDLE;
- starve_cnt = 0, timeout counter = 0, cancel bit = 0;
- err = 0, if_done = 0, d_done = 0;
- mem_req = 0, mem_we = 0;
- if_rdata, d_rdata, mem_addr and mem_wdata = 0.
REQ-018 A reset asserted mid-transaction SHALL abandon the transaction with no done pulse. The first grant after reset is deasserted SHALL occur no earlier than the first IDLE cycle.

Verification
REQ-019 Single fetch:
- Stimulus: if_req=1, if_addr=0x40, memory acks on the 3rd mem_req cycle with 0x00A00093.
- Response: mem_req during cycles 1-3, if_done at cycle 4 with if_rdata=0x00A00093, if_stall=0 at cycle 4.
REQ-020 Simultaneous requests:
- Stimulus: if_req=1 and d_req=1 (d_we=1, d_addr=0x100, d_wdata=0x55) in the same cycle.
- Response: a D write is issued first with mem_we=1; the I read is issued after d_done.
REQ-021 Anti-starvation:
- Stimulus: if_req held high while d_req stays high for three consecutive accesses.
- Response: the third grant goes to I; starve_cnt returns to 0.
REQ-022 Flush:
- Stimulus: if_flush pulsed during BUSY_I, then an ack with 0xDEADBEEF.
- Response: the transaction completes, if_done stays 0, and the state returns to IDLE.
REQ-023 Timeout:
- Stimulus: TIMEOUT=4, d_req=1, mem_ack never asserted.
- Response: err=1 after 4 BUSY cycles, d_done pulses with d_rdata=0, and err stays 1 until reset.
REQ-024 Mid-transaction reset:
- Stimulus: reset during BUSY_D.
- Response: next cycle mem_req=0, d_done=0 and state=IDLE; a later ack is ignored.
